lcd_sequencer: RTL and testbench

Command sequencer and bus arbiter for the HD44780-class character LCD. After reset it runs the fixed power-up initialisation sequence. It then shares the LCD byte interface between two requesters using round-robin arbitration, and enforces the controller's post-command execution delays. It sits between the text/status producers and the LCD strobe driver, which owns RS/RW/E/DB pin timing. The sequencer never touches the pins.

---
 rtl/lcd_sequencer_if.sv | 29 ++
 rtl/lcd_sequencer.sv | 143 ++++++++++++++
 tb/tb_lcd_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_sequencer_if.sv
// Byte-level link between the LCD sequencer, its two requesters and the strobe driver.
// The sequencer sits on the slave side; the requester/driver environment is the master.
interface lcd_sequencer_if;
  logic       a_req;
  logic       a_rs;
  logic [7:0] a_data;
  logic       a_ack;
  logic       b_req;
  logic       b_rs;
  logic [7:0] b_data;
  logic       b_ack;
  logic       bus_valid;
  logic       bus_rs;
  logic [7:0] bus_data;
  logic       bus_ready;
  logic       bus_done;
  logic       init_done;
  logic       busy;

  modport master (
    output a_req, a_rs, a_data, b_req, b_rs, b_data, bus_ready, bus_done,
    input  a_ack, b_ack, bus_valid, bus_rs, bus_data, init_done, busy
  );

  modport slave (
    input  a_req, a_rs, a_data, b_req, b_rs, b_data, bus_ready, bus_done,
    output a_ack, b_ack, bus_valid, bus_rs, bus_data, init_done, busy
  );
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 command sequencer: power-up init, round-robin sharing of the byte bus
// between two requesters, and post-command execution delays.
module lcd_sequencer #(
  parameter int POWERUP_CYC = 750000,
  parameter int CMD_CYC     = 2500,
  parameter int CLEAR_CYC   = 82000,
  parameter int CNT_W       = 20
) (
  input  logic            clk,
  input  logic            rst,
  lcd_sequencer_if.slave  lcd
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    ISSUE,
    XFER,
    HOLD,
    IDLE
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYC - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_last_b;
  logic             r_rs;
  logic [7:0]       r_data;
  logic             r_a_ack;
  logic             r_b_ack;
  logic             r_init_done;
  logic             w_cnt_zero;
  logic             w_grant_a;
  logic             w_grant_b;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0E;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Clear and home need the long execution time; everything else the short one.
  function automatic logic [CNT_W-1:0] hold_load(input logic rs, input logic [7:0] data);
    if (!rs && (data == 8'h01 || data == 8'h02)) return CLR_LOAD;
    return CMD_LOAD;
  endfunction

  assign w_cnt_zero = (r_cnt == '0);
  assign w_grant_a  = lcd.a_req & (~lcd.b_req | r_last_b);
  assign w_grant_b  = lcd.b_req & (~lcd.a_req | ~r_last_b);

  always_ff @(posedge clk) begin
    if (rst) r_state <= PWR_WAIT;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      PWR_WAIT: if (w_cnt_zero)    w_next_state = ISSUE;
      ISSUE:    if (lcd.bus_ready) w_next_state = XFER;
      XFER:     if (lcd.bus_done)  w_next_state = HOLD;
      HOLD:     if (w_cnt_zero)    w_next_state = (r_idx < 2'd3) ? ISSUE : IDLE;
      IDLE:     if (lcd.a_req || lcd.b_req) w_next_state = ISSUE;
      default:  w_next_state = PWR_WAIT;
    endcase
  end

  // rs/data only change on entry to ISSUE, so the offered byte is stable while valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= PWR_LOAD;
      r_idx       <= 2'd0;
      r_last_b    <= 1'b1;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        PWR_WAIT: begin
          if (w_cnt_zero) begin
            r_rs   <= 1'b0;
            r_data <= init_rom(2'd0);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        XFER: begin
          if (lcd.bus_done) r_cnt <= hold_load(r_rs, r_data);
        end
        HOLD: begin
          if (w_cnt_zero) begin
            if (r_idx < 2'd3) begin
              r_idx  <= r_idx + 2'd1;
              r_rs   <= 1'b0;
              r_data <= init_rom(r_idx + 2'd1);
            end else if (!r_init_done) begin
              r_init_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        IDLE: begin
          if (w_grant_a) begin
            r_rs     <= lcd.a_rs;
            r_data   <= lcd.a_data;
            r_a_ack  <= 1'b1;
            r_last_b <= 1'b0;
          end else if (w_grant_b) begin
            r_rs     <= lcd.b_rs;
            r_data   <= lcd.b_data;
            r_b_ack  <= 1'b1;
            r_last_b <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lcd.bus_valid = (r_state == ISSUE);
    lcd.bus_rs    = r_rs;
    lcd.bus_data  = r_data;
    lcd.a_ack     = r_a_ack;
    lcd.b_ack     = r_b_ack;
    lcd.init_done = r_init_done;
    lcd.busy      = (r_state != IDLE);
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a strobe-driver model that completes 3 cycles after accept.
module tb_lcd_sequencer;
  localparam int P  = 10;
  localparam int C  = 4;
  localparam int CL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_done = 1'b0;
  logic spur_done = 1'b0;

  always #5 clk = ~clk;

  lcd_sequencer_if ifc ();
  assign ifc.bus_done = drv_done | spur_done;

  lcd_sequencer #(
    .POWERUP_CYC(P),
    .CMD_CYC    (C),
    .CLEAR_CYC  (CL),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lcd(ifc.slave)
  );

  typedef struct {
    int         c;
    logic       rs;
    logic [7:0] d;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc;
  logic prev_v;
  ev_t  vq[$];
  int   aq[$];
  int   bq[$];
  int   idone_c;
  int   idle_c;

  // Strobe driver: bus_done is high in the third cycle after an accepted byte.
  initial begin
    int   cd;
    logic acc;
    cd = 0;
    forever begin
      @(posedge clk);
      acc = ifc.bus_valid && ifc.bus_ready;
      #1;
      drv_done = 1'b0;
      if (rst) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) drv_done = 1'b1;
        end
        if (acc) cd = 2;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (ifc.bus_valid && !prev_v) vq.push_back('{cyc, ifc.bus_rs, ifc.bus_data});
    prev_v = ifc.bus_valid;
    if (ifc.a_ack) aq.push_back(cyc);
    if (ifc.b_ack) bq.push_back(cyc);
    if (ifc.init_done && idone_c < 0) idone_c = cyc;
    if (!ifc.busy && idle_c < 0) idle_c = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_valid"}, 32'(ifc.bus_valid), 32'd0);
    chk({pfx, "_rs"},    32'(ifc.bus_rs),    32'd0);
    chk({pfx, "_data"},  32'(ifc.bus_data),  32'h00);
    chk({pfx, "_acks"},  32'({ifc.a_ack, ifc.b_ack}), 32'd0);
    chk({pfx, "_idone"}, 32'(ifc.init_done), 32'd0);
    chk({pfx, "_busy"},  32'(ifc.busy),      32'd1);
  endtask

  // Called at a negedge with rst high: releases it so this cycle is cycle 0.
  task automatic release_reset();
    rst = 1'b0;
    cyc = 0;
    vq.delete();
    aq.delete();
    bq.delete();
    idone_c = -1;
    idle_c  = -1;
    prev_v  = 1'b0;
    sample();
  endtask

  task automatic check_init(input string pfx);
    int         exp_c[4];
    logic [7:0] exp_d[4];
    exp_c = '{10, 18, 26, 34};
    exp_d = '{8'h38, 8'h0E, 8'h06, 8'h01};
    for (int i = 0; i < 80 && idone_c < 0; i++) step();
    chk({pfx, "_done_seen"}, 32'(idone_c >= 0), 32'd1);
    chk({pfx, "_nbytes"}, 32'(vq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < vq.size()) begin
        chk($sformatf("%s_byte%0d_cyc", pfx, i),  32'(vq[i].c),  32'(exp_c[i]));
        chk($sformatf("%s_byte%0d_data", pfx, i), 32'(vq[i].d),  32'(exp_d[i]));
        chk($sformatf("%s_byte%0d_rs", pfx, i),   32'(vq[i].rs), 32'd0);
      end
    end
    chk({pfx, "_idone_cyc"}, 32'(idone_c), 32'd46);
    chk({pfx, "_idle_cyc"},  32'(idle_c),  32'd46);
    chk({pfx, "_no_ack"},    32'(aq.size() + bq.size()), 32'd0);
  endtask

  initial begin
    int gq[$];
    int gd[$];
    int gc[$];
    int t;
    int h;
    logic stable;
    logic both;

    ifc.a_req = 1'b1; ifc.a_rs = 1'b1; ifc.a_data = 8'h50;
    ifc.b_req = 1'b0; ifc.b_rs = 1'b0; ifc.b_data = 8'h00;
    ifc.bus_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");

    // Init sequence with A requesting from cycle 0
    release_reset();
    check_init("init1");
    for (int i = 0; i < 10 && aq.size() == 0; i++) step();
    chk("a_ack_seen", 32'(aq.size()), 32'd1);
    if (aq.size() > 0) chk("a_ack_cyc", 32'(aq[0]), 32'd47);
    chk("a_bus_valid", 32'(ifc.bus_valid), 32'd1);
    chk("a_bus_data",  32'(ifc.bus_data),  32'h50);
    chk("a_bus_rs",    32'(ifc.bus_rs),    32'd1);
    ifc.a_req = 1'b0;
    repeat (12) step();
    chk("a_ack_once", 32'(aq.size()), 32'd1);

    // Both requesting: round-robin alternation
    ifc.a_req = 1'b1; ifc.a_rs = 1'b1; ifc.a_data = 8'h41;
    ifc.b_req = 1'b1; ifc.b_rs = 1'b1; ifc.b_data = 8'h42;
    both = 1'b0;
    for (int i = 0; i < 60 && gq.size() < 4; i++) begin
      step();
      if (ifc.a_ack && ifc.b_ack) both = 1'b1;
      if (ifc.a_ack || ifc.b_ack) begin
        gq.push_back(ifc.b_ack ? 1 : 0);
        gd.push_back(int'(ifc.bus_data));
        gc.push_back(cyc);
      end
    end
    ifc.a_req = 1'b0;
    ifc.b_req = 1'b0;
    chk("rr_count", 32'(gq.size()), 32'd4);
    chk("rr_no_dual_ack", 32'(both), 32'd0);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      chk($sformatf("rr_grant%0d_isB", i), 32'(gq[i]), 32'((i % 2 == 0) ? 1 : 0));
      chk($sformatf("rr_grant%0d_data", i), 32'(gd[i]), (i % 2 == 0) ? 32'h42 : 32'h41);
      if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(gc[i] - gc[i-1]), 32'd9);
    end
    repeat (12) step();

    // Stalled handshake with a spurious bus_done during ISSUE
    ifc.bus_ready = 1'b0;
    ifc.b_req = 1'b1; ifc.b_rs = 1'b1; ifc.b_data = 8'h5A;
    bq.delete();
    for (int i = 0; i < 6 && bq.size() == 0; i++) step();
    chk("stall_ack", 32'(bq.size()), 32'd1);
    ifc.b_req = 1'b0;
    stable = ifc.bus_valid && ifc.bus_data == 8'h5A && ifc.bus_rs;
    for (int k = 1; k <= 5; k++) begin
      step();
      stable = stable && ifc.bus_valid && ifc.bus_data == 8'h5A && ifc.bus_rs;
      if (k == 1) spur_done = 1'b1;
      if (k == 2) spur_done = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    ifc.bus_ready = 1'b1;
    h = cyc;
    step();
    chk("stall_valid_drop", 32'(ifc.bus_valid), 32'd0);
    idle_c = -1;
    for (int i = 0; i < 30 && idle_c < 0; i++) step();
    chk("stall_idle_cyc", 32'(idle_c - h), 32'd8);

    // Home with rs=0 takes the long delay; same byte as data takes the short one
    for (int r = 0; r < 2; r++) begin
      ifc.b_req = 1'b1; ifc.b_rs = (r == 1); ifc.b_data = 8'h02;
      bq.delete();
      for (int i = 0; i < 5 && bq.size() == 0; i++) step();
      chk($sformatf("home%0d_ack", r), 32'(bq.size()), 32'd1);
      ifc.b_req = 1'b0;
      t = cyc;
      idle_c = -1;
      for (int i = 0; i < 30 && idle_c < 0; i++) step();
      chk($sformatf("home%0d_ack_to_idle", r), 32'(idle_c - t), (r == 0) ? 32'd12 : 32'd8);
    end

    // Reset in the middle of HOLD
    ifc.b_req = 1'b1; ifc.b_rs = 1'b1; ifc.b_data = 8'h33;
    bq.delete();
    for (int i = 0; i < 5 && bq.size() == 0; i++) step();
    chk("mid_ack", 32'(bq.size()), 32'd1);
    ifc.b_req = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    check_reset_outputs("rst1");
    release_reset();
    check_init("init2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
